// File: rtl/pll_lock_reset_sequencer_pkg.sv
// rtl/pll_lock_reset_sequencer_pkg.sv - shared types and widths for the PLL lock reset sequencer
package pll_lock_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  localparam int NUM_STAGES = 4;

  localparam int FILTER_CYCLES_MAX = 65535;
  localparam int STAGE_DELAY_MAX   = 255;

  // Widths cover the full legal parameter ranges so any legal instance fits.
  localparam int FILTER_CNT_W = $clog2(FILTER_CYCLES_MAX + 1);
  localparam int STAGE_CNT_W  = $clog2(STAGE_DELAY_MAX + 1);
  localparam int LOSS_CNT_W   = 8;

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for asynchronous status inputs
module pll_lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// rtl/pll_lock_reset_sequencer.sv - filters PLL lock and releases four reset stages in order
module pll_lock_reset_sequencer
  import pll_lock_reset_sequencer_pkg::*;
#(
  parameter int FILTER_CYCLES = 1024,
  parameter int STAGE_DELAY   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  locked_sync,
  output logic                  seq_done,
  output logic [LOSS_CNT_W-1:0] lock_lost_count,
  output logic [1:0]            state
);

  localparam logic [FILTER_CNT_W-1:0] FILTER_LAST = FILTER_CNT_W'(FILTER_CYCLES - 1);
  localparam logic [STAGE_CNT_W-1:0]  STAGE_LAST  = STAGE_CNT_W'(STAGE_DELAY - 1);

  logic                    sync_lock;
  logic                    locked_prev_q;
  logic                    lock_fall;
  seq_state_e              state_q;
  logic [FILTER_CNT_W-1:0] filt_cnt_q;
  logic [STAGE_CNT_W-1:0]  stage_cnt_q;
  logic [NUM_STAGES-1:0]   rst_q;
  logic                    done_q;
  logic [LOSS_CNT_W-1:0]   loss_cnt_q;
  logic [LOSS_CNT_W-1:0]   loss_cnt_d;

  pll_lock_sync #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .async_i (pll_locked),
    .sync_o  (sync_lock)
  );

  // locked_prev_q resets to 0, so leaving reset never looks like a falling edge.
  assign lock_fall = locked_prev_q & ~sync_lock;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_fall && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_prev_q <= 1'b0;
      loss_cnt_q    <= '0;
      state_q       <= IDLE;
      filt_cnt_q    <= '0;
      stage_cnt_q   <= '0;
      rst_q         <= '0;
      done_q        <= 1'b0;
    end else begin
      locked_prev_q <= sync_lock;
      loss_cnt_q    <= loss_cnt_d;

      if ((state_q != IDLE) && !sync_lock) begin
        state_q     <= IDLE;
        filt_cnt_q  <= '0;
        stage_cnt_q <= '0;
        rst_q       <= '0;
        done_q      <= 1'b0;
      end else if (((state_q == RELEASE) || (state_q == RUN)) && sw_reset_req) begin
        // The request cycle counts as the first filtered cycle, like the IDLE entry.
        state_q     <= FILTER;
        filt_cnt_q  <= FILTER_CNT_W'(1);
        stage_cnt_q <= '0;
        rst_q       <= '0;
        done_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            rst_q       <= '0;
            done_q      <= 1'b0;
            stage_cnt_q <= '0;
            if (sync_lock) begin
              state_q    <= FILTER;
              filt_cnt_q <= FILTER_CNT_W'(1);
            end else begin
              filt_cnt_q <= '0;
            end
          end
          FILTER: begin
            if (filt_cnt_q == FILTER_LAST) begin
              state_q     <= RELEASE;
              filt_cnt_q  <= '0;
              stage_cnt_q <= '0;
              rst_q       <= NUM_STAGES'(1);
            end else begin
              filt_cnt_q <= filt_cnt_q + 1'b1;
            end
          end
          RELEASE: begin
            if (stage_cnt_q == STAGE_LAST) begin
              stage_cnt_q <= '0;
              rst_q       <= {rst_q[NUM_STAGES-2:0], 1'b1};
              if (rst_q[NUM_STAGES-2]) begin
                state_q <= RUN;
                done_q  <= 1'b1;
              end
            end else begin
              stage_cnt_q <= stage_cnt_q + 1'b1;
            end
          end
          RUN: begin
            done_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rst_out_n       = rst_q;
  assign locked_sync     = sync_lock;
  assign seq_done        = done_q;
  assign lock_lost_count = loss_cnt_q;
  assign state           = state_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// tb/tb_pll_lock_reset_sequencer.sv - directed self-checking bench for pll_lock_reset_sequencer
module tb_pll_lock_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic [3:0] rst_out_n;
  logic       locked_sync;
  logic       seq_done;
  logic [7:0] lock_lost_count;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  pll_lock_reset_sequencer #(
    .FILTER_CYCLES (8),
    .STAGE_DELAY   (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .sw_reset_req    (sw_reset_req),
    .rst_out_n       (rst_out_n),
    .locked_sync     (locked_sync),
    .seq_done        (seq_done),
    .lock_lost_count (lock_lost_count),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k = cycles since the first counted lock cycle (or the sw request cycle)
  function automatic logic [3:0] exp_rst(int k);
    if (k >= 20) return 4'b1111;
    if (k >= 16) return 4'b0111;
    if (k >= 12) return 4'b0011;
    if (k >= 8)  return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] exp_state(int n);
    if (n < 3)  return 2'd0;
    if (n < 10) return 2'd1;
    if (n < 22) return 2'd2;
    return 2'd3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic bring_up();
    do_reset();
    pll_locked = 1'b1;
    repeat (24) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b1; pll_locked = 1'b0; sw_reset_req = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rst_out_n !== 4'b0000) begin errors++; $display("FAIL reset_rst: got %b want 0000", rst_out_n); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", seq_done); end
    checks++; if (locked_sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b want 0", locked_sync); end
    checks++; if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", lock_lost_count); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    checks++; if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL reset_release_count: got %0d want 0", lock_lost_count); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_release_state: got %0d want 0", state); end
  endtask

  task automatic test_sequence();
    do_reset();
    pll_locked = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      checks++; if (rst_out_n !== exp_rst(n - 2)) begin errors++; $display("FAIL seq_rst c%0d: got %b want %b", n, rst_out_n, exp_rst(n - 2)); end
      checks++; if (seq_done !== logic'(n >= 22)) begin errors++; $display("FAIL seq_done c%0d: got %b want %b", n, seq_done, n >= 22); end
      checks++; if (locked_sync !== logic'(n >= 2)) begin errors++; $display("FAIL seq_sync c%0d: got %b want %b", n, locked_sync, n >= 2); end
      checks++; if (state !== exp_state(n)) begin errors++; $display("FAIL seq_state c%0d: got %0d want %0d", n, state, exp_state(n)); end
    end
  endtask

  task automatic test_filter_glitch();
    do_reset();
    pll_locked = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 7) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL glitch_filter c7: got %0d want 1", state); end
      end
      if (n == 8) begin
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL glitch_idle c8: got %0d want 0", state); end
      end
      if (n >= 8 && n <= 17) begin
        checks++; if (rst_out_n !== 4'b0000) begin errors++; $display("FAIL glitch_hold c%0d: got %b want 0000", n, rst_out_n); end
      end
      if (n == 18) begin
        checks++; if (rst_out_n !== 4'b0001) begin errors++; $display("FAIL glitch_release c18: got %b want 0001", rst_out_n); end
      end
      if (n == 5) pll_locked = 1'b0;
      if (n == 8) pll_locked = 1'b1;
    end
    checks++; if (lock_lost_count !== 8'd1) begin errors++; $display("FAIL glitch_count: got %0d want 1", lock_lost_count); end
  endtask

  task automatic test_lock_loss_run();
    bring_up();
    pll_locked = 1'b0;
    repeat (2) tick();
    checks++; if (rst_out_n !== 4'b1111) begin errors++; $display("FAIL loss_before: got %b want 1111", rst_out_n); end
    checks++; if (locked_sync !== 1'b0) begin errors++; $display("FAIL loss_sync: got %b want 0", locked_sync); end
    tick();
    checks++; if (rst_out_n !== 4'b0000) begin errors++; $display("FAIL loss_rst: got %b want 0000", rst_out_n); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL loss_state: got %0d want 0", state); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL loss_done: got %b want 0", seq_done); end
    checks++; if (lock_lost_count !== 8'd1) begin errors++; $display("FAIL loss_count: got %0d want 1", lock_lost_count); end
  endtask

  task automatic test_sw_reset();
    bring_up();
    sw_reset_req = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      sw_reset_req = 1'b0;
      if (k == 1) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL sw_state: got %0d want 1", state); end
      end
      if (k == 1 || k == 7 || k == 8 || k == 11 || k == 12 || k == 16 || k == 19 || k == 20) begin
        checks++; if (rst_out_n !== exp_rst(k)) begin errors++; $display("FAIL sw_rst +%0d: got %b want %b", k, rst_out_n, exp_rst(k)); end
      end
      if (k == 19 || k == 20) begin
        checks++; if (seq_done !== logic'(k == 20)) begin errors++; $display("FAIL sw_done +%0d: got %b want %b", k, seq_done, k == 20); end
      end
    end
    checks++; if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL sw_count: got %0d want 0", lock_lost_count); end
  endtask

  task automatic test_sw_ignored_filter();
    do_reset();
    pll_locked = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      sw_reset_req = (n == 5);
      if (n == 9) begin
        checks++; if (rst_out_n !== 4'b0000) begin errors++; $display("FAIL swign_hold c9: got %b want 0000", rst_out_n); end
      end
      if (n == 10) begin
        checks++; if (rst_out_n !== 4'b0001) begin errors++; $display("FAIL swign_release c10: got %b want 0001", rst_out_n); end
      end
    end
    sw_reset_req = 1'b0;
  endtask

  task automatic test_same_cycle();
    bring_up();
    pll_locked = 1'b0;
    repeat (2) tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL same_state: got %0d want 0", state); end
    checks++; if (rst_out_n !== 4'b0000) begin errors++; $display("FAIL same_rst: got %b want 0000", rst_out_n); end
    checks++; if (lock_lost_count !== 8'd1) begin errors++; $display("FAIL same_count: got %0d want 1", lock_lost_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b1;
      repeat (4) tick();
      pll_locked = 1'b0;
      repeat (4) tick();
      if (i == 253) begin
        checks++; if (lock_lost_count !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", lock_lost_count); end
      end
      if (i == 254) begin
        checks++; if (lock_lost_count !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", lock_lost_count); end
      end
    end
    checks++; if (lock_lost_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", lock_lost_count); end
  endtask

  task automatic test_reset_mid_release();
    do_reset();
    pll_locked = 1'b1;
    repeat (15) tick();
    checks++; if (rst_out_n !== 4'b0011) begin errors++; $display("FAIL midrst_pre: got %b want 0011", rst_out_n); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rst_out_n !== 4'b0000) begin errors++; $display("FAIL midrst_rst: got %b want 0000", rst_out_n); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d want 0", state); end
    checks++; if (locked_sync !== 1'b0) begin errors++; $display("FAIL midrst_sync: got %b want 0", locked_sync); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", seq_done); end
    tick();
    reset_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 9) begin
        checks++; if (rst_out_n !== 4'b0000) begin errors++; $display("FAIL midrst_hold c9: got %b want 0000", rst_out_n); end
      end
      if (n == 10) begin
        checks++; if (rst_out_n !== 4'b0001) begin errors++; $display("FAIL midrst_release c10: got %b want 0001", rst_out_n); end
      end
    end
    checks++; if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", lock_lost_count); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_filter_glitch();
    test_lock_loss_run();
    test_sw_reset();
    test_sw_ignored_filter();
    test_same_cycle();
    test_saturation();
    test_reset_mid_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
